// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter time-sharing one ALU between two requesters, with a
// per-port response register and valid/ready handshake on each side.
module alu_share_arbiter #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  // port 0 request
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_alu_op,
  input  logic [2:0]       req0_func3,
  input  logic             req0_func7,
  input  logic [XLEN-1:0]  req0_op_a,
  input  logic [XLEN-1:0]  req0_op_b,
  input  logic [TAG_W-1:0] req0_tag,
  // port 1 request
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_alu_op,
  input  logic [2:0]       req1_func3,
  input  logic             req1_func7,
  input  logic [XLEN-1:0]  req1_op_a,
  input  logic [XLEN-1:0]  req1_op_b,
  input  logic [TAG_W-1:0] req1_tag,
  // port 0 response
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [XLEN-1:0]  rsp0_data,
  output logic             rsp0_zero,
  output logic [TAG_W-1:0] rsp0_tag,
  // port 1 response
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [XLEN-1:0]  rsp1_data,
  output logic             rsp1_zero,
  output logic [TAG_W-1:0] rsp1_tag,
  // shared ALU
  output logic [2:0]       alu_op_o,
  output logic [2:0]       alu_func3_o,
  output logic             alu_func7_o,
  output logic [XLEN-1:0]  alu_a_o,
  output logic [XLEN-1:0]  alu_b_o,
  input  logic [XLEN-1:0]  alu_result_i,
  input  logic             alu_zero_i
);

  logic             r_rsp0_valid;
  logic [XLEN-1:0]  r_rsp0_data;
  logic             r_rsp0_zero;
  logic [TAG_W-1:0] r_rsp0_tag;
  logic             r_rsp1_valid;
  logic [XLEN-1:0]  r_rsp1_data;
  logic             r_rsp1_zero;
  logic [TAG_W-1:0] r_rsp1_tag;
  logic             r_last_grant;

  logic w_elig0;
  logic w_elig1;
  logic w_grant0;
  logic w_grant1;

  // A port may be granted only if its response slot is empty or draining now.
  assign w_elig0 = req0_valid & (~r_rsp0_valid | rsp0_ready);
  assign w_elig1 = req1_valid & (~r_rsp1_valid | rsp1_ready);

  // On contention the port that did not win last time takes the grant.
  assign w_grant0 = w_elig0 & (~w_elig1 | r_last_grant);
  assign w_grant1 = w_elig1 & (~w_elig0 | ~r_last_grant);

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  always_comb begin
    alu_op_o    = 3'b000;
    alu_func3_o = 3'b000;
    alu_func7_o = 1'b0;
    alu_a_o     = '0;
    alu_b_o     = '0;
    if (w_grant0) begin
      alu_op_o    = req0_alu_op;
      alu_func3_o = req0_func3;
      alu_func7_o = req0_func7;
      alu_a_o     = req0_op_a;
      alu_b_o     = req0_op_b;
    end else if (w_grant1) begin
      alu_op_o    = req1_alu_op;
      alu_func3_o = req1_func3;
      alu_func7_o = req1_func7;
      alu_a_o     = req1_op_a;
      alu_b_o     = req1_op_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rsp0_valid <= 1'b0;
      r_rsp0_data  <= '0;
      r_rsp0_zero  <= 1'b0;
      r_rsp0_tag   <= '0;
      r_rsp1_valid <= 1'b0;
      r_rsp1_data  <= '0;
      r_rsp1_zero  <= 1'b0;
      r_rsp1_tag   <= '0;
      r_last_grant <= 1'b1;
    end else begin
      // A grant reloads the slot even when it drains in the same cycle.
      if (w_grant0) begin
        r_rsp0_valid <= 1'b1;
        r_rsp0_data  <= alu_result_i;
        r_rsp0_zero  <= alu_zero_i;
        r_rsp0_tag   <= req0_tag;
      end else if (rsp0_ready) begin
        r_rsp0_valid <= 1'b0;
      end
      if (w_grant1) begin
        r_rsp1_valid <= 1'b1;
        r_rsp1_data  <= alu_result_i;
        r_rsp1_zero  <= alu_zero_i;
        r_rsp1_tag   <= req1_tag;
      end else if (rsp1_ready) begin
        r_rsp1_valid <= 1'b0;
      end
      if (w_grant0) begin
        r_last_grant <= 1'b0;
      end else if (w_grant1) begin
        r_last_grant <= 1'b1;
      end
    end
  end

  assign rsp0_valid = r_rsp0_valid;
  assign rsp0_data  = r_rsp0_data;
  assign rsp0_zero  = r_rsp0_zero;
  assign rsp0_tag   = r_rsp0_tag;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp1_data  = r_rsp1_data;
  assign rsp1_zero  = r_rsp1_zero;
  assign rsp1_tag   = r_rsp1_tag;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU on the
// shared datapath; every check is an immediate assertion.
module tb_alu_share_arbiter;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 4;

  logic             clk;
  logic             rstn;
  logic             req0_valid, req0_ready, req0_func7;
  logic [2:0]       req0_alu_op, req0_func3;
  logic [XLEN-1:0]  req0_op_a, req0_op_b;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid, req1_ready, req1_func7;
  logic [2:0]       req1_alu_op, req1_func3;
  logic [XLEN-1:0]  req1_op_a, req1_op_b;
  logic [TAG_W-1:0] req1_tag;
  logic             rsp0_valid, rsp0_ready, rsp0_zero;
  logic [XLEN-1:0]  rsp0_data;
  logic [TAG_W-1:0] rsp0_tag;
  logic             rsp1_valid, rsp1_ready, rsp1_zero;
  logic [XLEN-1:0]  rsp1_data;
  logic [TAG_W-1:0] rsp1_tag;
  logic [2:0]       alu_op_o, alu_func3_o;
  logic             alu_func7_o;
  logic [XLEN-1:0]  alu_a_o, alu_b_o, alu_result_i;
  logic             alu_zero_i;

  int n_assert;
  int n_fail;

  alu_share_arbiter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_alu_op(req0_alu_op),
    .req0_func3(req0_func3), .req0_func7(req0_func7), .req0_op_a(req0_op_a),
    .req0_op_b(req0_op_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_alu_op(req1_alu_op),
    .req1_func3(req1_func3), .req1_func7(req1_func7), .req1_op_a(req1_op_a),
    .req1_op_b(req1_op_b), .req1_tag(req1_tag),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp0_zero(rsp0_zero), .rsp0_tag(rsp0_tag),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .rsp1_zero(rsp1_zero), .rsp1_tag(rsp1_tag),
    .alu_op_o(alu_op_o), .alu_func3_o(alu_func3_o), .alu_func7_o(alu_func7_o),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural shared ALU: add/branch-subtract/R-type/I-type subset.
  always_comb begin
    alu_result_i = '0;
    case (alu_op_o)
      3'b000: alu_result_i = alu_a_o + alu_b_o;
      3'b001: alu_result_i = alu_a_o - alu_b_o;
      3'b010, 3'b011: begin
        case (alu_func3_o)
          3'b000: alu_result_i = (alu_op_o == 3'b010 && alu_func7_o) ? alu_a_o - alu_b_o
                                                                      : alu_a_o + alu_b_o;
          3'b001: alu_result_i = alu_a_o << alu_b_o[4:0];
          3'b100: alu_result_i = alu_a_o ^ alu_b_o;
          3'b101: alu_result_i = alu_a_o >> alu_b_o[4:0];
          3'b110: alu_result_i = alu_a_o | alu_b_o;
          3'b111: alu_result_i = alu_a_o & alu_b_o;
          default: alu_result_i = '0;
        endcase
      end
      3'b100: alu_result_i = alu_a_o + 32'd4;
      default: alu_result_i = '0;
    endcase
    alu_zero_i = (alu_result_i == '0);
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [2:0] op, input logic [2:0] f3,
                      input logic f7, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag);
    req0_valid = v; req0_alu_op = op; req0_func3 = f3; req0_func7 = f7;
    req0_op_a = a; req0_op_b = b; req0_tag = tag;
  endtask

  task automatic set1(input logic v, input logic [2:0] op, input logic [2:0] f3,
                      input logic f7, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag);
    req1_valid = v; req1_alu_op = op; req1_func3 = f3; req1_func7 = f7;
    req1_op_a = a; req1_op_b = b; req1_tag = tag;
  endtask

  initial begin
    logic exp_g0;
    n_assert = 0;
    n_fail   = 0;
    rstn = 1'b0;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    set0(1'b0, 3'd0, 3'd0, 1'b0, 32'd0, 32'd0, 4'd0);
    set1(1'b0, 3'd0, 3'd0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (2) tick();

    // Reset state
    chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("rst_rsp0_data", rsp0_data, 32'd0);
    chk("rst_rsp0_tag", 32'(rsp0_tag), 32'd0);
    chk("rst_rsp0_zero", 32'(rsp0_zero), 32'd0);
    chk("rst_rsp1_data", rsp1_data, 32'd0);
    chk("idle_alu_a", alu_a_o, 32'd0);
    chk("idle_alu_op", 32'(alu_op_o), 32'd0);
    chk("idle_req0_ready", 32'(req0_ready), 32'd0);
    rstn = 1'b1;

    // 1: port 0 alone, R-type SUB 5-3
    set0(1'b1, 3'b010, 3'b000, 1'b1, 32'd5, 32'd3, 4'd2);
    #1;
    chk("t1_req0_ready", 32'(req0_ready), 32'd1);
    chk("t1_req1_ready", 32'(req1_ready), 32'd0);
    chk("t1_alu_op", 32'(alu_op_o), 32'd2);
    chk("t1_alu_a", alu_a_o, 32'd5);
    tick();
    req0_valid = 1'b0;
    chk("t1_rsp0_valid", 32'(rsp0_valid), 32'd1);
    chk("t1_rsp0_data", rsp0_data, 32'd2);
    chk("t1_rsp0_tag", 32'(rsp0_tag), 32'd2);
    chk("t1_rsp1_valid", 32'(rsp1_valid), 32'd0);
    rsp0_ready = 1'b1;
    #1;
    chk("t1_no_req_ready", 32'(req0_ready), 32'd0);
    tick();
    chk("t1_drained", 32'(rsp0_valid), 32'd0);

    // 5: branch compare on port 1 alone, a == b
    set1(1'b1, 3'b001, 3'b000, 1'b0, 32'd7, 32'd7, 4'd1);
    #1;
    chk("t5_req1_ready", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    chk("t5_rsp1_valid", 32'(rsp1_valid), 32'd1);
    chk("t5_rsp1_zero", 32'(rsp1_zero), 32'd1);
    chk("t5_rsp1_data", rsp1_data, 32'd0);
    chk("t5_rsp1_tag", 32'(rsp1_tag), 32'd1);

    // 2: continuous contention alternates 0,1,0,1
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    set0(1'b1, 3'b000, 3'b000, 1'b0, 32'd1, 32'd1, 4'd3);
    set1(1'b1, 3'b010, 3'b100, 1'b0, 32'hF, 32'h3, 4'd5);
    for (int i = 0; i < 4; i++) begin
      exp_g0 = ((i % 2) == 0);
      #1;
      chk("t2_req0_ready", 32'(req0_ready), 32'(exp_g0));
      chk("t2_req1_ready", 32'(req1_ready), 32'(!exp_g0));
      tick();
      chk("t2_rsp0_valid", 32'(rsp0_valid), 32'(exp_g0));
      chk("t2_rsp1_valid", 32'(rsp1_valid), 32'(!exp_g0));
      chk("t2_rsp_data", exp_g0 ? rsp0_data : rsp1_data, exp_g0 ? 32'd2 : 32'hC);
    end

    // 3: port 0 backpressured with a full slot; port 1 runs every cycle
    set1(1'b0, 3'd0, 3'd0, 1'b0, 32'd0, 32'd0, 4'd0);
    set0(1'b1, 3'b000, 3'b000, 1'b0, 32'd10, 32'd20, 4'd7);
    rsp0_ready = 1'b0;
    #1;
    chk("t3_fill_ready", 32'(req0_ready), 32'd1);
    tick();
    chk("t3_fill_data", rsp0_data, 32'd30);
    set0(1'b1, 3'b000, 3'b000, 1'b0, 32'd99, 32'd1, 4'd8);
    for (int i = 0; i < 3; i++) begin
      set1(1'b1, 3'b000, 3'b000, 1'b0, 32'(i), 32'd100, 4'd9);
      #1;
      chk("t3_req0_ready", 32'(req0_ready), 32'd0);
      chk("t3_req1_ready", 32'(req1_ready), 32'd1);
      tick();
      chk("t3_rsp0_valid", 32'(rsp0_valid), 32'd1);
      chk("t3_rsp0_data", rsp0_data, 32'd30);
      chk("t3_rsp0_tag", 32'(rsp0_tag), 32'd7);
      chk("t3_rsp1_data", rsp1_data, 32'd100 + 32'(i));
    end

    // 4: full slot draining while a new port 0 request is granted
    set1(1'b0, 3'd0, 3'd0, 1'b0, 32'd0, 32'd0, 4'd0);
    set0(1'b1, 3'b000, 3'b000, 1'b0, 32'd40, 32'd2, 4'd4);
    rsp0_ready = 1'b1;
    #1;
    chk("t4_req0_ready", 32'(req0_ready), 32'd1);
    tick();
    chk("t4_rsp0_valid", 32'(rsp0_valid), 32'd1);
    chk("t4_rsp0_data", rsp0_data, 32'd42);
    chk("t4_rsp0_tag", 32'(rsp0_tag), 32'd4);

    // 6: reset right after grants to both ports
    set0(1'b0, 3'd0, 3'd0, 1'b0, 32'd0, 32'd0, 4'd0);
    set1(1'b1, 3'b000, 3'b000, 1'b0, 32'd3, 32'd4, 4'd6);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b1;
    #1;
    chk("t6_grant1", 32'(req1_ready), 32'd1);
    tick();
    set0(1'b1, 3'b000, 3'b000, 1'b0, 32'd8, 32'd8, 4'd11);
    rsp0_ready = 1'b1;
    #1;
    chk("t6_grant0", 32'(req0_ready), 32'd1);
    tick();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    rstn = 1'b0;
    tick();
    chk("t6_rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("t6_rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    rstn = 1'b1;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    #1;
    chk("t6_post_req0_ready", 32'(req0_ready), 32'd1);
    chk("t6_post_req1_ready", 32'(req1_ready), 32'd0);
    tick();
    chk("t6_post_rsp0_valid", 32'(rsp0_valid), 32'd1);
    chk("t6_post_rsp0_data", rsp0_data, 32'd16);
    chk("t6_post_rsp1_valid", 32'(rsp1_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
